// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit holding the HI/LO pair.
// Multiply is shift-add, divide is restoring shift-subtract, one step per clock.
// Optional feature macro: MDU_DIV_EN (divider datapath; without it DIV/DIVU pulse illegal).
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned AW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [AW-1:0]   acc;       // multiply: {partial product, multiplier}; divide: {remainder, quotient}
    logic [WIDTH-1:0] mcand;    // multiplicand magnitude, or divisor magnitude
    logic            neg_res;   // product / quotient must be negated at FIX

    logic             is_signed_c;
    logic             a_neg_c;
    logic             b_neg_c;
    logic [WIDTH-1:0] abs_a_c;
    logic [WIDTH-1:0] abs_b_c;
    logic [WIDTH:0]   mul_sum_c;
    logic [AW-1:0]    mul_step_c;
    logic [AW-1:0]    acc_step_c;
    logic [AW-1:0]    prod_c;
    logic [WIDTH-1:0] res_hi_c;
    logic [WIDTH-1:0] res_lo_c;

`ifdef MDU_DIV_EN
    logic             is_div;
    logic             div_zero;
    logic             neg_rem;  // remainder takes the dividend's sign
    logic [WIDTH:0]   div_part_c;
    logic [WIDTH+1:0] div_diff_c;
    logic [AW-1:0]    div_step_c;
    logic [WIDTH-1:0] quot_c;
    logic [WIDTH-1:0] rem_c;
`endif

    // Operand magnitudes for the signed ops (MULT, DIV have op[0]=0)
    always_comb begin
        is_signed_c = ~op[0];
        a_neg_c     = is_signed_c & src_a[WIDTH-1];
        b_neg_c     = is_signed_c & src_b[WIDTH-1];
        abs_a_c     = a_neg_c ? -src_a : src_a;
        abs_b_c     = b_neg_c ? -src_b : src_b;
    end

    // One iteration of the selected algorithm
    always_comb begin
        mul_sum_c  = {1'b0, acc[AW-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        mul_step_c = {mul_sum_c, acc[WIDTH-1:1]};
        acc_step_c = mul_step_c;
`ifdef MDU_DIV_EN
        div_part_c = acc[AW-1:WIDTH-1];
        div_diff_c = {1'b0, div_part_c} - {2'b00, mcand};
        if (div_diff_c[WIDTH+1])
            div_step_c = {div_part_c[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        else
            div_step_c = {div_diff_c[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        if (is_div)
            acc_step_c = div_step_c;
`endif
    end

    // Sign correction of the finished accumulator
    always_comb begin
        prod_c   = neg_res ? -acc : acc;
        res_hi_c = prod_c[AW-1:WIDTH];
        res_lo_c = prod_c[WIDTH-1:0];
`ifdef MDU_DIV_EN
        // Divide by zero leaves all-ones quotient and the dividend as remainder
        quot_c = div_zero ? {WIDTH{1'b1}} : (neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
        rem_c  = neg_rem ? -acc[AW-1:WIDTH] : acc[AW-1:WIDTH];
        if (is_div) begin
            res_hi_c = rem_c;
            res_lo_c = quot_c;
        end
`endif
    end

    // Control FSM, iteration state and HI/LO registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            count    <= '0;
            acc      <= '0;
            mcand    <= '0;
            neg_res  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            illegal  <= 1'b0;
            hi       <= '0;
            lo       <= '0;
`ifdef MDU_DIV_EN
            is_div   <= 1'b0;
            div_zero <= 1'b0;
            neg_rem  <= 1'b0;
`endif
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                IDLE: begin
                    if (mthi)
                        hi <= src_a;
                    if (mtlo)
                        lo <= src_a;
                    if (start) begin
`ifdef MDU_DIV_EN
                        acc      <= op[1] ? {{WIDTH{1'b0}}, abs_a_c} : {{WIDTH{1'b0}}, abs_b_c};
                        mcand    <= op[1] ? abs_b_c : abs_a_c;
                        neg_res  <= a_neg_c ^ b_neg_c;
                        neg_rem  <= a_neg_c;
                        is_div   <= op[1];
                        div_zero <= (src_b == '0);
                        count    <= '0;
                        busy     <= 1'b1;
                        state    <= CALC;
`else
                        if (op[1]) begin
                            illegal <= 1'b1;
                        end else begin
                            acc     <= {{WIDTH{1'b0}}, abs_b_c};
                            mcand   <= abs_a_c;
                            neg_res <= a_neg_c ^ b_neg_c;
                            count   <= '0;
                            busy    <= 1'b1;
                            state   <= CALC;
                        end
`endif
                    end
                end
                CALC: begin
                    acc   <= acc_step_c;
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1))
                        state <= FIX;
                end
                FIX: begin
                    hi    <= res_hi_c;
                    lo    <= res_lo_c;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
